// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronises the PS/2 clock and data lines, glitch-filters the clock and
// produces a one-cycle strobe on each filtered falling edge.
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic kclk_i,
    input  logic kdata_i,
    output logic kclk_filt_o,
    output logic kdata_o,
    output logic fall_o
);

    localparam int unsigned CW = 4;

    logic [1:0]    kclk_sync_q, kclk_sync_d;
    logic [1:0]    kdata_sync_q, kdata_sync_d;
    logic          kclk_filt_q, kclk_filt_d;
    logic [CW-1:0] flt_cnt_q, flt_cnt_d;
    logic          fall_q, fall_d;

    // Next state: shift synchronisers, count disagreeing samples, detect falls
    always_comb begin
        kclk_sync_d  = {kclk_sync_q[0], kclk_i};
        kdata_sync_d = {kdata_sync_q[0], kdata_i};
        kclk_filt_d  = kclk_filt_q;
        flt_cnt_d    = '0;
        if (kclk_sync_q[1] != kclk_filt_q) begin
            // Flip only on the FILTER_LEN-th consecutive differing sample
            if (flt_cnt_q == CW'(FILTER_LEN - 1)) begin
                kclk_filt_d = kclk_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
        fall_d = kclk_filt_q & ~kclk_filt_d;
    end

    // State registers; lines idle high so everything resets high
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            kclk_sync_q  <= 2'b11;
            kdata_sync_q <= 2'b11;
            kclk_filt_q  <= 1'b1;
            flt_cnt_q    <= '0;
            fall_q       <= 1'b0;
        end else begin
            kclk_sync_q  <= kclk_sync_d;
            kdata_sync_q <= kdata_sync_d;
            kclk_filt_q  <= kclk_filt_d;
            flt_cnt_q    <= flt_cnt_d;
            fall_q       <= fall_d;
        end
    end

    assign kclk_filt_o = kclk_filt_q;
    assign kdata_o     = kdata_sync_q[1];
    assign fall_o      = fall_q;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: frame FSM, E0/F0 prefix decoder and show-ahead
// event FIFO read through a valid/ready handshake.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SKIP_BREAK  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk,
    input  logic       kdata,
    output logic [7:0] kout,
    output logic       kext,
    output logic       krel,
    output logic       kvalid,
    input  logic       kready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic stb, kdat, kclk_filt_unused;

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_sync_filter (
        .clk_i      (clk),
        .rst_i      (rst),
        .kclk_i     (kclk),
        .kdata_i    (kdata),
        .kclk_filt_o(kclk_filt_unused),
        .kdata_o    (kdat),
        .fall_o     (stb)
    );

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_vld_q, byte_vld_d;
    logic [7:0]    byte_q, byte_d;
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          flag_clr;

    // Frame FSM: steps on the sample strobe, aborts on inter-edge timeout
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        byte_vld_d   = 1'b0;
        byte_d       = byte_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        flag_clr     = 1'b0;
        tmo_d        = (state_q == StIdle || stb) ? '0 : tmo_q + 1'b1;

        if (state_q != StIdle && !stb && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
            flag_clr    = 1'b1;
            tmo_d       = '0;
        end else if (stb) begin
            unique case (state_q)
                StIdle: begin
                    if (!kdat) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d = {kdat, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                StParity: begin
                    par_ok_d = (^shift_q) ^ kdat;
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (!kdat) begin
                        frame_err_d = 1'b1;
                        flag_clr    = 1'b1;
                    end else if (!par_ok_q) begin
                        parity_err_d = 1'b1;
                        flag_clr     = 1'b1;
                    end else begin
                        byte_vld_d = 1'b1;
                        byte_d     = shift_q;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    logic     ext_q, ext_d;
    logic     rel_q, rel_d;
    logic     push_req;
    ps2_evt_t evt;

    // Prefix decoder: runs the cycle after a byte is accepted
    always_comb begin
        ext_d    = ext_q;
        rel_d    = rel_q;
        push_req = 1'b0;
        evt      = '{ext: ext_q, rel: rel_q, code: byte_q};
        if (flag_clr) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end else if (byte_vld_q) begin
            if (byte_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (byte_q == PS2_BRK) begin
                rel_d = 1'b1;
            end else begin
                ext_d    = 1'b0;
                rel_d    = 1'b0;
                push_req = !(rel_q && SKIP_BREAK != 0);
            end
        end
    end

    ps2_evt_t    mem_q [FIFO_DEPTH];
    ps2_evt_t    mem_d [FIFO_DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        overflow_q, overflow_d;
    logic        empty, full, pop, push;
    ps2_evt_t    head;

    // FIFO: a pop frees a slot for a same-cycle push even when full
    always_comb begin
        empty      = (wptr_q == rptr_q);
        full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop        = !empty && kready;
        push       = push_req && (!full || pop);
        overflow_d = push_req && full && !pop;
        mem_d      = mem_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = evt;
        end
        wptr_d = wptr_q + (AW + 1)'(push);
        rptr_d = rptr_q + (AW + 1)'(pop);
        head   = mem_q[rptr_q[AW-1:0]];
    end

    // State registers for FSM, decoder and FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_ok_q     <= 1'b0;
            tmo_q        <= '0;
            byte_vld_q   <= 1'b0;
            byte_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ext_q        <= 1'b0;
            rel_q        <= 1'b0;
            mem_q        <= '{default: '0};
            wptr_q       <= '0;
            rptr_q       <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            tmo_q        <= tmo_d;
            byte_vld_q   <= byte_vld_d;
            byte_q       <= byte_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            ext_q        <= ext_d;
            rel_q        <= rel_d;
            mem_q        <= mem_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            overflow_q   <= overflow_d;
        end
    end

    // Head fields read as zero while the FIFO is empty
    assign kvalid     = !empty;
    assign kout       = empty ? 8'h00 : head.code;
    assign kext       = !empty && head.ext;
    assign krel       = !empty && head.rel;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: two instances (SKIP_BREAK=1 and 0) share the
// PS/2 lines; expected events go into per-instance scoreboard queues.
module tb_ps2_key_receiver;

    localparam int HALF = 20;
    localparam int TMO  = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic kclk = 1'b1;
    logic kdata = 1'b1;
    logic kready = 1'b1;

    logic [7:0] kout_a, kout_b;
    logic kext_a, krel_a, kvalid_a, perr_a, ferr_a, ovf_a;
    logic kext_b, krel_b, kvalid_b, perr_b, ferr_b, ovf_b;

    ps2_key_receiver #(
        .FILTER_LEN(4), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(4), .SKIP_BREAK(1)
    ) dut_a (
        .clk(clk), .rst(rst), .kclk(kclk), .kdata(kdata),
        .kout(kout_a), .kext(kext_a), .krel(krel_a), .kvalid(kvalid_a), .kready(kready),
        .parity_err(perr_a), .frame_err(ferr_a), .overflow(ovf_a)
    );

    ps2_key_receiver #(
        .FILTER_LEN(4), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(4), .SKIP_BREAK(0)
    ) dut_b (
        .clk(clk), .rst(rst), .kclk(kclk), .kdata(kdata),
        .kout(kout_b), .kext(kext_b), .krel(krel_b), .kvalid(kvalid_b), .kready(kready),
        .parity_err(perr_b), .frame_err(ferr_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [9:0] qa[$];
    logic [9:0] qb[$];
    logic [9:0] ea, eb;
    int pa = 0, fa = 0, oa = 0, pb = 0, fb = 0, ob = 0;
    int va = 0, vb = 0;
    int spa, sfa, soa, spb, sfb, sob;

    // Monitor: tally pulses and compare every handshake against the queues
    always @(negedge clk) begin
        if (!rst) begin
            pa += int'(perr_a); fa += int'(ferr_a); oa += int'(ovf_a);
            pb += int'(perr_b); fb += int'(ferr_b); ob += int'(ovf_b);
            va += int'(kvalid_a); vb += int'(kvalid_b);
            if (kvalid_a && kready) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++;
                    $display("FAIL evt_a unexpected got=%h required=none", {kext_a, krel_a, kout_a});
                end else begin
                    ea = qa.pop_front();
                    if ({kext_a, krel_a, kout_a} !== ea) begin
                        failures++;
                        $display("FAIL evt_a got=%h required=%h", {kext_a, krel_a, kout_a}, ea);
                    end
                end
            end
            if (kvalid_b && kready) begin
                checks++;
                if (qb.size() == 0) begin
                    failures++;
                    $display("FAIL evt_b unexpected got=%h required=none", {kext_b, krel_b, kout_b});
                end else begin
                    eb = qb.pop_front();
                    if ({kext_b, krel_b, kout_b} !== eb) begin
                        failures++;
                        $display("FAIL evt_b got=%h required=%h", {kext_b, krel_b, kout_b}, eb);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic snap();
        spa = pa; sfa = fa; soa = oa; spb = pb; sfb = fb; sob = ob;
    endtask

    task automatic check_errs(input string tag, input int ep, input int ef, input int eo);
        check({tag, "_perr_a"}, pa - spa, ep);
        check({tag, "_ferr_a"}, fa - sfa, ef);
        check({tag, "_ovf_a"},  oa - soa, eo);
        check({tag, "_perr_b"}, pb - spb, ep);
        check({tag, "_ferr_b"}, fb - sfb, ef);
        check({tag, "_ovf_b"},  ob - sob, eo);
    endtask

    task automatic send_bit(input logic b);
        kdata = b;
        repeat (HALF) @(posedge clk);
        kclk = 1'b0;
        repeat (HALF) @(posedge clk);
        kclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic pflip, input logic sbad);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit(~(^code) ^ pflip);
        send_bit(~sbad);
        kdata = 1'b1;
        repeat (HALF * 4) @(posedge clk);
    endtask

    typedef struct {
        logic [7:0] code;
        logic       pflip;
        logic       sbad;
        logic       push_a;
        logic [9:0] ev_a;
        logic       push_b;
        logic [9:0] ev_b;
        int         perr;
        int         ferr;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int na, nb;
        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h01C, 1'b1, 10'h01C, 0, 0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 0, 0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h11C, 0, 0};
        vecs[3]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h01C, 1'b1, 10'h01C, 0, 0};
        vecs[4]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 0, 0};
        vecs[5]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 0, 0};
        vecs[6]  = '{8'h75, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 10'h375, 0, 0};
        vecs[7]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 0, 0};
        vecs[8]  = '{8'h74, 1'b0, 1'b0, 1'b1, 10'h274, 1'b1, 10'h274, 0, 0};
        vecs[9]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1, 0};
        vecs[10] = '{8'h1C, 1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 0, 1};
        vecs[11] = '{8'h5A, 1'b0, 1'b0, 1'b1, 10'h05A, 1'b1, 10'h05A, 0, 0};
        vecs[12] = '{8'hE0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 0, 0};
        vecs[13] = '{8'h6B, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1, 0};
        vecs[14] = '{8'h1C, 1'b0, 1'b0, 1'b1, 10'h01C, 1'b1, 10'h01C, 0, 0};

        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset_a", {kout_a, kext_a, krel_a, kvalid_a, perr_a, ferr_a, ovf_a}, 0);
        check("reset_b", {kout_b, kext_b, krel_b, kvalid_b, perr_b, ferr_b, ovf_b}, 0);
        @(posedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        // Table-driven frames with kready held high
        na = 0; nb = 0;
        va = 0; vb = 0;
        for (int i = 0; i < 15; i++) begin
            snap();
            if (vecs[i].push_a) begin qa.push_back(vecs[i].ev_a); na++; end
            if (vecs[i].push_b) begin qb.push_back(vecs[i].ev_b); nb++; end
            send_frame(vecs[i].code, vecs[i].pflip, vecs[i].sbad);
            check_errs($sformatf("v%0d", i), vecs[i].perr, vecs[i].ferr, 0);
        end
        // With kready=1 each event is visible for exactly one cycle
        check("valid_cycles_a", va, na);
        check("valid_cycles_b", vb, nb);
        check("drain_a", qa.size(), 0);
        check("drain_b", qb.size(), 0);

        // Clock stops after 4 data bits: timeout, then a clean frame
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        kdata = 1'b1;
        repeat (TMO + 100) @(posedge clk);
        check_errs("tmo", 0, 1, 0);
        qa.push_back(10'h01C);
        qb.push_back(10'h01C);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("tmo_next_a", qa.size(), 0);
        check("tmo_next_b", qb.size(), 0);

        // Short kclk glitches with data low must never start a frame
        snap();
        kdata = 1'b0;
        for (int i = 0; i < 5; i++) begin
            kclk = 1'b0;
            repeat (2) @(posedge clk);
            kclk = 1'b1;
            repeat (10) @(posedge clk);
        end
        repeat (TMO + 100) @(posedge clk);
        kdata = 1'b1;
        repeat (20) @(posedge clk);
        check_errs("glitch", 0, 0, 0);

        // Reset mid-frame after an E0 prefix: no error, prefix forgotten
        send_frame(8'hE0, 1'b0, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        kdata = 1'b1;
        @(posedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        rst = 1'b0;
        snap();
        repeat (TMO + 100) @(posedge clk);
        check_errs("midrst", 0, 0, 0);
        qa.push_back(10'h01C);
        qb.push_back(10'h01C);
        send_frame(8'h1C, 1'b0, 1'b0);
        check("midrst_evt_a", qa.size(), 0);
        check("midrst_evt_b", qb.size(), 0);

        // Five frames into a depth-4 FIFO with the consumer stalled
        kready = 1'b0;
        snap();
        for (int i = 0; i < 5; i++) begin
            logic [7:0] c;
            c = 8'(8'h11 * (i + 1));
            if (i < 4) begin
                qa.push_back({2'b00, c});
                qb.push_back({2'b00, c});
            end
            send_frame(c, 1'b0, 1'b0);
        end
        check_errs("ovf", 0, 0, 1);
        @(negedge clk);
        check("stall_valid", {kvalid_a, kvalid_b}, 2'b11);
        kready = 1'b1;
        repeat (50) @(posedge clk);
        check("ovf_drain_a", qa.size(), 0);
        check("ovf_drain_b", qb.size(), 0);
        @(negedge clk);
        check("final_empty", {kvalid_a, kvalid_b}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
